md_hilo_unit: RTL and testbench
===============================

// Module: md_hilo_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with architectural HI/LO registers for the P6 pipeline.
//  Sits in the E stage and consumes the MDCCtrl op code and the SrcA/SrcB operands.
//  Computes the result, then holds Busy high for a fixed latency before committing HI/LO.
//  HI/LO feed the mfhi/mflo path; the hazard unit stalls md ops in D while Start|Busy.
// PARAMETERS
//  MULT_CYCLES  5   cycles Busy stays high for mult/multu (legal range 1..15)
//  DIV_CYCLES   10  cycles Busy stays high for div/divu (legal range 1..15)
// PORTS
//  clk       in   1   single clock; all state updates on the rising edge
//  reset     in   1   synchronous, active-high; sampled on the rising edge of clk
//  Start     in   1   E stage holds a valid md op this cycle (one-cycle pulse per instr)
//  MDCCtrl   in   3   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 reserved(=none)
//  SrcA      in   32  rs operand (dividend / multiplicand / mthi-mtlo data)
//  SrcB      in   32  rt operand (divisor / multiplier)
//  Busy      out  1   registered; high while a mult/div is in flight
//  HI        out  32  architectural HI register
//  LO        out  32  architectural LO register
// BEHAVIOUR
//  Reset: Busy=0, HI=0, LO=0, counter=0, result regs=0; takes effect at any point, aborting in-flight op.
//  States:
//   - IDLE (Busy=0):
//       Start & op in 1..4 -> latch result, cnt<=N, go BUSY at that edge.
//       Start & op 5 -> HI<=SrcA at the edge, no Busy.
//       Start & op 6 -> LO<=SrcA at the edge, no Busy.
//   - BUSY (Busy=1): each edge cnt<=cnt-1. At the edge where cnt==1:
//       HI/LO <= latched result, Busy<=0, back to IDLE.
//   - Busy is high for exactly N cycles after the Start edge (N = MULT_CYCLES or DIV_CYCLES).
//   - New HI/LO are visible in the first cycle with Busy=0.
//  Start while Busy: ignored. The hazard unit guarantees this never happens; the latched result is untouched.
//  Start with op 0 or 7: no effect.
//  Arithmetic, computed from SrcA/SrcB at the Start edge:
//   - mult: signed 64-bit product -> {HI,LO}.
//   - multu: unsigned 64-bit product -> {HI,LO}.
//   - div: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
//       0x80000000 / -1 -> LO=0x80000000, HI=0.
//   - divu: unsigned quotient -> LO, unsigned remainder -> HI.
//  Divide by zero: the unit still goes Busy for DIV_CYCLES, but HI/LO stay unchanged at completion.
//  No partial update: HI/LO change only at completion, or on mthi/mtlo, or on reset.
// STRUCTURE
//  md_defs.vh (shared include):
//   - MD_NONE/MD_MULT/MD_MULTU/MD_DIV/MD_DIVU/MD_MTHI/MD_MTLO op codes.
//   - Default cycle counts.
//   - Used by the controller and the hazard unit.
//  md_arith (combinational sub-module):
//   - Inputs: SrcA, SrcB, op.
//   - Outputs: res_hi, res_lo, div_zero.
//   - Holds all multiply/divide arithmetic.
//  md_hilo_unit itself holds: the counter/FSM, latched result, HI/LO registers, mthi/mtlo writes.
// TESTING
//  mult:
//   - A=0xFFFFFFFD, B=5, Start@T.
//   - Busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//  multu:
//   - A=0xFFFFFFFF, B=2.
//   - Response after 5 cycles: HI=0x00000001, LO=0xFFFFFFFE.
//  div:
//   - A=0xFFFFFFF9 (-7), B=2.
//   - Busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  divu:
//   - A=7, B=2.
//   - Response: LO=3, HI=1.
//  div by 0:
//   - Preload mthi 0x12345678, mtlo 0x9ABCDEF0.
//   - Then div A=5, B=0 -> Busy 10 cycles, HI/LO unchanged.
//   - Next cycle, mthi A=0xAAAA5555 -> HI=0xAAAA5555 one edge later, Busy stays 0.
//  reset mid-op:
//   - Start div, assert reset at cycle 4 of Busy.
//   - Next edge: Busy=0, HI=LO=0, no later commit.
//   - A Start pulse during Busy is ignored (result matches the first op).

Source files
------------

// File: rtl/md_hilo_unit_pkg.sv
// Shared op codes, FSM states and default latencies for the multiply/divide unit.
// Used by the controller and by the hazard unit's md-op detection.
package md_hilo_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
  localparam int unsigned MD_CNT_W           = 4;

  function automatic logic md_is_long_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_hilo_unit_arith.sv
// Combinational multiply/divide datapath for md_hilo_unit.
// Signed divide works on magnitudes so the INT_MIN / -1 case wraps cleanly to INT_MIN.
module md_hilo_unit_arith
  import md_hilo_unit_pkg::*;
(
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  md_op_e      op,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] w_a_s64;
  logic signed [63:0] w_b_s64;
  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic               w_is_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic        [31:0] w_mag_a;
  logic        [31:0] w_mag_b;
  logic        [31:0] w_divisor;
  logic        [31:0] w_q_mag;
  logic        [31:0] w_r_mag;
  logic        [31:0] w_quot;
  logic        [31:0] w_rem;

  assign w_a_s64  = $signed({{32{SrcA[31]}}, SrcA});
  assign w_b_s64  = $signed({{32{SrcB[31]}}, SrcB});
  assign w_prod_s = w_a_s64 * w_b_s64;
  assign w_prod_u = {32'd0, SrcA} * {32'd0, SrcB};

  assign div_zero    = (SrcB == 32'd0);
  assign w_is_signed = (op == MD_DIV);
  assign w_neg_a     = w_is_signed & SrcA[31];
  assign w_neg_b     = w_is_signed & SrcB[31];
  assign w_mag_a     = w_neg_a ? (32'd0 - SrcA) : SrcA;
  assign w_mag_b     = w_neg_b ? (32'd0 - SrcB) : SrcB;
  // Divisor forced to 1 on zero so the datapath never produces X; result is discarded anyway.
  assign w_divisor   = div_zero ? 32'd1 : w_mag_b;
  assign w_q_mag     = w_mag_a / w_divisor;
  assign w_r_mag     = w_mag_a % w_divisor;
  assign w_quot      = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem       = w_neg_a ? (32'd0 - w_r_mag) : w_r_mag;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (op)
      MD_MULT: begin
        res_hi = w_prod_s[63:32];
        res_lo = w_prod_s[31:0];
      end
      MD_MULTU: begin
        res_hi = w_prod_u[63:32];
        res_lo = w_prod_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        res_hi = w_rem;
        res_lo = w_quot;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_hilo_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the E stage.
// Result is captured at Start, then committed to HI/LO after a fixed Busy latency.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_IDLE | Busy=0; accepts mult/div (go busy) and mthi/mtlo (direct write)
//  ST_BUSY | Busy=1; counting down, commits latched result when cnt==1
module md_hilo_unit
  import md_hilo_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDCCtrl,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [MD_CNT_W-1:0] LP_MULT_N = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] LP_DIV_N  = MD_CNT_W'(DIV_CYCLES);

  md_state_e           r_state;
  md_state_e           w_state_nxt;
  logic [MD_CNT_W-1:0] r_cnt;
  logic [MD_CNT_W-1:0] w_cnt_nxt;
  logic [31:0]         r_res_hi;
  logic [31:0]         r_res_lo;
  logic                r_div_zero;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;

  md_op_e              w_op;
  logic [31:0]         w_res_hi;
  logic [31:0]         w_res_lo;
  logic                w_div_zero;
  logic                w_latch;
  logic                w_commit;
  logic                w_idle_start;

  assign w_op         = md_op_e'(MDCCtrl);
  assign w_idle_start = (r_state == ST_IDLE) && Start;

  md_hilo_unit_arith u_arith (
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .op       (w_op),
    .res_hi   (w_res_hi),
    .res_lo   (w_res_lo),
    .div_zero (w_div_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (Start && md_is_long_op(w_op)) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = md_is_div_op(w_op) ? LP_DIV_N : LP_MULT_N;
          w_latch     = 1'b1;
        end
      end
      ST_BUSY: begin
        if (r_cnt == MD_CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt - MD_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_res_hi   <= '0;
      r_res_lo   <= '0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_res_hi   <= w_res_hi;
        r_res_lo   <= w_res_lo;
        r_div_zero <= md_is_div_op(w_op) && w_div_zero;
      end
    end
  end

  // Divide-by-zero still burns the full latency but leaves HI/LO untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (!r_div_zero) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
    end else if (w_idle_start) begin
      if (w_op == MD_MTHI) r_hi <= SrcA;
      if (w_op == MD_MTLO) r_lo <= SrcA;
    end
  end

  assign Busy = (r_state == ST_BUSY);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_md_hilo_unit.sv
// Self-checking bench for md_hilo_unit: directed vectors plus random ops
// against a plain-arithmetic HI/LO model.
module tb_md_hilo_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDCCtrl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks;
  int n_fail;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_hilo_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .MDCCtrl (MDCCtrl),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .Busy    (Busy),
    .HI      (HI),
    .LO      (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin pu = {32'd0, a} * {32'd0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; end
      3'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int exp_latency(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MULT_N;
    if (op == 3'd3 || op == 3'd4) return DIV_N;
    return 0;
  endfunction

  // Called at a negedge; leaves at the first negedge where Busy has dropped.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    int cnt;
    Start = 1'b1; MDCCtrl = op; SrcA = a; SrcB = b;
    @(negedge clk);
    Start = 1'b0; MDCCtrl = 3'd0; SrcA = $urandom; SrcB = $urandom;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    model_apply(op, a, b);
    n_checks++;
    if (cnt !== exp_latency(op)) begin
      n_fail++;
      $display("FAIL %s busy_cycles op=%0d got=%0d exp=%0d", name, op, cnt, exp_latency(op));
    end
    n_checks++;
    if (HI !== m_hi) begin
      n_fail++;
      $display("FAIL %s HI op=%0d a=%h b=%h got=%h exp=%h", name, op, a, b, HI, m_hi);
    end
    n_checks++;
    if (LO !== m_lo) begin
      n_fail++;
      $display("FAIL %s LO op=%0d a=%h b=%h got=%h exp=%h", name, op, a, b, LO, m_lo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state got busy=%b hi=%h lo=%h exp busy=0 hi=0 lo=0", Busy, HI, LO);
    end
  endtask

  task automatic test_directed();
    run_op("mult",  3'd1, 32'hFFFF_FFFD, 32'd5);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2);
    run_op("divu",  3'd4, 32'd7, 32'd2);
    run_op("div_intmin", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("none",  3'd0, 32'hDEAD_BEEF, 32'd1);
    run_op("rsvd",  3'd7, 32'hDEAD_BEEF, 32'd1);
  endtask

  task automatic test_div_zero();
    run_op("mthi_pre", 3'd5, 32'h1234_5678, 32'd0);
    run_op("mtlo_pre", 3'd6, 32'h9ABC_DEF0, 32'd0);
    run_op("div0",     3'd3, 32'd5, 32'd0);
    run_op("divu0",    3'd4, 32'd5, 32'd0);
    run_op("mthi_post", 3'd5, 32'hAAAA_5555, 32'd0);
  endtask

  task automatic test_start_while_busy();
    int cnt;
    Start = 1'b1; MDCCtrl = 3'd2; SrcA = 32'hFFFF_FFFF; SrcB = 32'd3;
    @(negedge clk);
    Start = 1'b0; MDCCtrl = 3'd0;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 40) begin
      cnt++;
      if (cnt == 2) begin
        Start = 1'b1; MDCCtrl = 3'd3; SrcA = 32'd7; SrcB = 32'd2;
      end else if (cnt == 3) begin
        Start = 1'b1; MDCCtrl = 3'd5; SrcA = 32'h5555_AAAA;
      end else begin
        Start = 1'b0; MDCCtrl = 3'd0;
      end
      @(negedge clk);
    end
    Start = 1'b0; MDCCtrl = 3'd0;
    model_apply(3'd2, 32'hFFFF_FFFF, 32'd3);
    n_checks++;
    if (cnt !== MULT_N) begin
      n_fail++;
      $display("FAIL busy_ignore busy_cycles got=%0d exp=%0d", cnt, MULT_N);
    end
    n_checks++;
    if (HI !== m_hi || LO !== m_lo) begin
      n_fail++;
      $display("FAIL busy_ignore result got=%h_%h exp=%h_%h", HI, LO, m_hi, m_lo);
    end
  endtask

  task automatic test_reset_mid_op();
    run_op("mthi_rst_pre", 3'd5, 32'h1111_2222, 32'd0);
    Start = 1'b1; MDCCtrl = 3'd3; SrcA = 32'd100; SrcB = 32'd7;
    @(negedge clk);
    Start = 1'b0; MDCCtrl = 3'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid busy_before got=%b exp=1", Busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid after got busy=%b hi=%h lo=%h exp busy=0 hi=0 lo=0", Busy, HI, LO);
    end
    repeat (15) @(negedge clk);
    n_checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid no_commit got busy=%b hi=%h lo=%h exp busy=0 hi=0 lo=0", Busy, HI, LO);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (i % 13 == 5) begin op = 3'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      run_op("random", op, a, b);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; Start = 1'b0; MDCCtrl = 3'd0; SrcA = '0; SrcB = '0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
